// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, BCD field
// width and limits, and a preset validity helper.
package timer_pkg;

   localparam int BCD_W = 8;

   localparam logic [BCD_W-1:0] BCD_MS_MAX = 8'h59;
   localparam logic [BCD_W-1:0] BCD_HH_MAX = 8'h23;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Nibble check first, so the plain numeric compare against max is a BCD compare.
   function automatic logic bcd_valid(input logic [BCD_W-1:0] value,
                                      input logic [BCD_W-1:0] max);
      return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
   endfunction

endpackage

// File: rtl/bcd_dec2.sv
// Two-digit BCD decrement: with borrow-in, subtracts one; at 00 it wraps to
// i_wrap and raises borrow-out. Without borrow-in the value passes through.
module bcd_dec2
   import timer_pkg::*;
(
   input  logic [BCD_W-1:0] i_val,
   input  logic             i_borrow,
   input  logic [BCD_W-1:0] i_wrap,
   output logic [BCD_W-1:0] o_val,
   output logic             o_borrow
);

   // NOTE: every output of a combinational block gets a default up front so
   // no path through the ifs leaves it unassigned (which would infer a latch).
   always_comb begin
      o_val    = i_val;
      o_borrow = 1'b0;
      if (i_borrow) begin
         if (i_val == '0) begin
            o_val    = i_wrap;
            o_borrow = 1'b1;
         end else if (i_val[3:0] == 4'd0) begin
            o_val = {i_val[7:4] - 4'd1, 4'd9};
         end else begin
            o_val = {i_val[7:4], i_val[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/timer_countdown.sv
// HH:MM:SS BCD countdown timer with load/start/stop/ack controls and a
// one-second prescaler; raises alarm when the count reaches 00:00:00.
module timer_countdown
   import timer_pkg::*;
#(
   parameter int TICK_CYCLES = 100000000
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BCD_W-1:0] preset_hh,
   input  logic [BCD_W-1:0] preset_mm,
   input  logic [BCD_W-1:0] preset_ss,
   input  logic             start,
   input  logic             stop,
   input  logic             ack,
   output logic [BCD_W-1:0] count_hh,
   output logic [BCD_W-1:0] count_mm,
   output logic [BCD_W-1:0] count_ss,
   output logic             running,
   output logic             alarm
);

   localparam int             PW         = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [BCD_W-1:0] r_hh, r_mm, r_ss;
   logic [PW-1:0]    r_presc;
   logic             r_running, r_alarm;

   logic [BCD_W-1:0] w_hh_dec, w_mm_dec, w_ss_dec;
   logic             w_ss_borrow, w_mm_borrow, w_hh_borrow;
   logic             w_tick, w_preset_ok, w_load_en, w_count_nz, w_dec_zero;

   assign w_tick      = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
   assign w_preset_ok = bcd_valid(preset_hh, BCD_HH_MAX) &&
                        bcd_valid(preset_mm, BCD_MS_MAX) &&
                        bcd_valid(preset_ss, BCD_MS_MAX);
   assign w_load_en   = load && w_preset_ok && (r_state != ST_RUN);
   assign w_count_nz  = |{r_hh, r_mm, r_ss};
   assign w_dec_zero  = ~|{w_hh_dec, w_mm_dec, w_ss_dec};

   bcd_dec2 u_dec_ss (.i_val(r_ss), .i_borrow(w_tick),      .i_wrap(BCD_MS_MAX),
                      .o_val(w_ss_dec), .o_borrow(w_ss_borrow));
   bcd_dec2 u_dec_mm (.i_val(r_mm), .i_borrow(w_ss_borrow), .i_wrap(BCD_MS_MAX),
                      .o_val(w_mm_dec), .o_borrow(w_mm_borrow));
   bcd_dec2 u_dec_hh (.i_val(r_hh), .i_borrow(w_mm_borrow), .i_wrap(BCD_HH_MAX),
                      .o_val(w_hh_dec), .o_borrow(w_hh_borrow));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_load_en)                            w_state_nxt = ST_IDLE;
                   else if (start && !stop && w_count_nz)    w_state_nxt = ST_RUN;
         ST_RUN:   if (w_tick && w_dec_zero)                 w_state_nxt = ST_DONE;
                   else if (stop)                            w_state_nxt = ST_PAUSE;
         ST_PAUSE: if (w_load_en)                            w_state_nxt = ST_IDLE;
                   else if (start && !stop && w_count_nz)    w_state_nxt = ST_RUN;
         ST_DONE:  if (w_load_en || ack)                     w_state_nxt = ST_IDLE;
         default:                                            w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_hh      <= '0;
         r_mm      <= '0;
         r_ss      <= '0;
         r_presc   <= '0;
         r_running <= 1'b0;
         r_alarm   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_alarm   <= (w_state_nxt == ST_DONE);

         if (w_load_en) begin
            r_hh <= preset_hh;
            r_mm <= preset_mm;
            r_ss <= preset_ss;
         end else if (w_tick) begin
            r_hh <= w_hh_dec;
            r_mm <= w_mm_dec;
            r_ss <= w_ss_dec;
         end

         // Advances on every RUN cycle including the stop edge, then holds in
         // PAUSE, so a paused second resumes with no cycle lost or repeated.
         if (r_state == ST_RUN)
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
         else if (r_state == ST_IDLE && w_state_nxt == ST_RUN)
            r_presc <= '0;
      end
   end

   assign count_hh = r_hh;
   assign count_mm = r_mm;
   assign count_ss = r_ss;
   assign running  = r_running;
   assign alarm    = r_alarm;

endmodule

// File: doc/timer_countdown.md
TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000000, clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load  input  1  single-cycle pulse; capture preset fields.
REQ-005 SHALL have port preset_hh  input  8  BCD hours preset, 00-23.
REQ-006 SHALL have port preset_mm  input  8  BCD minutes preset, 00-59.
REQ-007 SHALL have port preset_ss  input  8  BCD seconds preset, 00-59.
REQ-008 SHALL have port start  input  1  single-cycle pulse; begin or resume counting.
REQ-009 SHALL have port stop  input  1  single-cycle pulse; pause counting.
REQ-010 SHALL have port ack  input  1  single-cycle pulse; clear alarm.
REQ-011 SHALL have ports count_hh, count_mm, count_ss  output  8 each  current BCD count; feeds display holding registers.
REQ-012 SHALL have port running  output  1  high only in state RUN.
REQ-013 SHALL have port alarm  output  1  high only in state DONE.

Function
REQ-014 SHALL implement a state machine with states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-015 load in IDLE, PAUSE or DONE SHALL copy the presets to the counts on the next edge and enter IDLE; in RUN, load SHALL be ignored.
REQ-016 A preset SHALL be rejected, with counts and state unchanged, if any nibble is >9, mm or ss >0x59, or hh >0x23.
REQ-017 start in IDLE or PAUSE with a nonzero count SHALL enter RUN next edge; in IDLE the prescaler SHALL clear, in PAUSE it SHALL resume from its held value.
REQ-018 start with count 00:00:00 SHALL be ignored.
REQ-019 In RUN, the prescaler SHALL count 0..TICK_CYCLES-1 and wrap; a tick occurs on the cycle it equals TICK_CYCLES-1.
REQ-020 Each tick SHALL decrement the count by one second in BCD: ss 00->59 with borrow to mm; mm 00->59 with borrow to hh; hh decrements on borrow.
REQ-021 A tick producing 00:00:00 SHALL enter DONE on the same edge the count updates; alarm and running change on that edge.
REQ-022 stop in RUN SHALL enter PAUSE next edge and freeze the prescaler; stop elsewhere SHALL be ignored.
REQ-023 If start and stop assert together, stop SHALL win (RUN->PAUSE; IDLE/PAUSE unchanged).
REQ-024 If a tick and stop coincide, the decrement SHALL apply and the state SHALL become PAUSE, or DONE if the count reaches zero.
REQ-025 ack in DONE SHALL enter IDLE with counts held at 00:00:00; ack elsewhere SHALL be ignored.
REQ-026 If load and ack coincide in DONE, load SHALL apply (REQ-015).
REQ-027 Count fields SHALL never hold an invalid BCD value.

Reset
REQ-028 reset SHALL force IDLE, counts 00:00:00, prescaler 0, running 0, alarm 0, immediately and independent of clk.
REQ-029 Reset asserted mid-RUN SHALL discard the partial tick; no decrement occurs on reset release.

Structure
REQ-030 A shared package timer_pkg SHALL hold the state enum, BCD limit constants (0x59, 0x23), and the BCD field width.
REQ-031 A sub-module bcd_dec2 SHALL implement a two-digit BCD decrement with borrow-in, borrow-out and a wrap value; it SHALL be instantiated three times.
REQ-032 The prescaler width SHALL be $clog2(TICK_CYCLES).

Verification (TICK_CYCLES=4)
REQ-033 Load 00:01:02, then start -> after 4 cycles 00:01:01, after 8 cycles 00:01:00, after 12 cycles 00:00:59.
REQ-034 Load 01:00:00, then start -> first tick gives 00:59:59.
REQ-035 Load 00:00:02, start -> alarm=1 and running=0 on the same edge the count reaches 00:00:00; ack -> IDLE, alarm=0.
REQ-036 In RUN with prescaler=2, stop; wait 20 cycles; start -> next tick after exactly 1 cycle, no count change while paused.
REQ-037 Load 00:61:00 -> counts unchanged; start with count 00:00:00 -> state stays IDLE.
REQ-038 Reset pulse mid-RUN at 00:00:05 -> outputs 00:00:00, running=0, alarm=0 before the next clk edge.
